// File: rtl/mem_pkg.sv
// Shared types and helpers for the pipelined main memory.
//   mem_state_e      : init / run state of the array controller
//   mem_resp_flags_t : control half of one response pipeline stage
//   mem_byte_lanes() : number of byte lanes in a data word
package mem_pkg;

  typedef enum logic [0:0] {
    MEM_INIT,
    MEM_RUN
  } mem_state_e;

  // Data is kept beside this struct in each stage because its width is a module parameter.
  typedef struct packed {
    logic valid;
    logic err;
  } mem_resp_flags_t;

  function automatic int unsigned mem_byte_lanes(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency response shift register for main_memory_pipe.
// Stage 0 is loaded every cycle from the request side. The remaining stages shift
// every cycle. Outputs come from the last stage, so a response appears LATENCY
// cycles after the request cycle.
// Ports:
//   clk, reset          : clock, asynchronous active-high clear of all stages
//   i_valid/i_err/i_data: response captured at the accept edge
//   o_valid/o_err/o_data: response presented to the requester
module mem_resp_pipe
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic                  i_err,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_data
);

  typedef struct packed {
    mem_resp_flags_t       flags;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  stage_t r_stage [LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0].flags.valid <= i_valid;
      r_stage[0].flags.err   <= i_err;
      r_stage[0].data        <= i_data;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_valid = r_stage[LATENCY-1].flags.valid;
  assign o_err   = r_stage[LATENCY-1].flags.err;
  assign o_data  = r_stage[LATENCY-1].data;

endmodule

// File: rtl/main_memory_pipe.sv
// Word-addressed single-port RAM with a valid/ready request port, byte enables,
// a fixed read latency and a range check. After reset the whole array is zeroed,
// one word per cycle, before any request is accepted.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   req_valid/req_ready        : request handshake (ready only once init is done)
//   req_we/req_addr/req_wdata/req_be : write flag, word address, data, byte enables
//   resp_valid/resp_rdata/resp_err   : one response per accepted request
// Optional build macro MEM_STATS_EN adds rd_count/wr_count (wrapping) and
// err_count (saturating) traffic counters.
module main_memory_pipe
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]             rd_count,
  output logic [31:0]             wr_count,
  output logic [15:0]             err_count
`endif
);

  localparam int unsigned NumBytes = mem_byte_lanes(DATA_WIDTH);
  localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  mem_state_e            r_state, w_state_next;
  logic [IdxWidth-1:0]   r_init_cnt, w_init_cnt_next;

  logic                  w_accept;
  logic                  w_in_range;
  logic [IdxWidth-1:0]   w_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_stage_err;
  logic [DATA_WIDTH-1:0] w_stage_data;

  // Init / run controller.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= MEM_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_init_cnt <= w_init_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_init_cnt_next = r_init_cnt;
    req_ready       = 1'b0;
    unique case (r_state)
      MEM_INIT: begin
        if (r_init_cnt == IdxWidth'(DEPTH - 1)) begin
          w_init_cnt_next = '0;
          w_state_next    = MEM_RUN;
        end else begin
          w_init_cnt_next = r_init_cnt + 1'b1;
        end
      end
      MEM_RUN: req_ready = 1'b1;
      default: w_state_next = MEM_INIT;
    endcase
  end

  assign w_accept = req_valid && req_ready;
  // Full-width compare so that high address bits never alias into the array.
  assign w_in_range = (req_addr < ADDR_WIDTH'(DEPTH));
  assign w_idx      = req_addr[IdxWidth-1:0];
  assign w_rd_word  = r_mem[w_idx];

  // Array: zeroed word by word during init, byte-masked writes during run.
  always_ff @(posedge clk) begin
    if (r_state == MEM_INIT) begin
      r_mem[r_init_cnt] <= '0;
    end else if (w_accept && req_we && w_in_range) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (req_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Idle stages carry zero data so resp_rdata is 0 whenever resp_valid is low.
  assign w_stage_err  = w_accept && !w_in_range;
  assign w_stage_data = (w_accept && w_in_range && !req_we) ? w_rd_word : '0;

  mem_resp_pipe #(
    .LATENCY    (READ_LATENCY),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_resp_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_accept),
    .i_err   (w_stage_err),
    .i_data  (w_stage_data),
    .o_valid (resp_valid),
    .o_err   (resp_err),
    .o_data  (resp_rdata)
  );

`ifdef MEM_STATS_EN
  logic [31:0] r_rd_count, r_wr_count;
  logic [15:0] r_err_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_count  <= '0;
      r_wr_count  <= '0;
      r_err_count <= '0;
    end else if (w_accept) begin
      if (!w_in_range) begin
        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
      end else if (req_we) begin
        r_wr_count <= r_wr_count + 32'd1;
      end else begin
        r_rd_count <= r_rd_count + 32'd1;
      end
    end
  end

  assign rd_count  = r_rd_count;
  assign wr_count  = r_wr_count;
  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_main_memory_pipe.sv
// Scoreboard bench for main_memory_pipe. Three instances (READ_LATENCY 2, 1, 4)
// share one request stream. Each issued request pushes its hand-computed
// response and request cycle into exp_q; one monitor per instance walks the
// queue with its own pointer and checks data, error flag and latency.
module tb_main_memory_pipe;

  localparam int NDut = 3;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        req_ready  [NDut];
  logic        resp_valid [NDut];
  logic [31:0] resp_rdata [NDut];
  logic        resp_err   [NDut];
`ifdef MEM_STATS_EN
  logic [31:0] rd_cnt  [NDut];
  logic [31:0] wr_cnt  [NDut];
  logic [15:0] err_cnt [NDut];
  int          exp_rd, exp_wr, exp_err_cnt;
`endif

  exp_t exp_q[$];
  int   ptr [NDut];
  int   cyc;
  int   n_pass;
  int   n_total;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int g, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %h, expected %h", name, g, act, exp);
  endtask

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    localparam int Lat = (g == 0) ? 2 : (g == 1) ? 1 : 4;

    main_memory_pipe #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .DEPTH        (256),
      .READ_LATENCY (Lat)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready[g]),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .resp_valid (resp_valid[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
`ifdef MEM_STATS_EN
      ,
      .rd_count   (rd_cnt[g]),
      .wr_count   (wr_cnt[g]),
      .err_count  (err_cnt[g])
`endif
    );

    always @(negedge clk) begin
      exp_t e;
      if (resp_valid[g] === 1'b1) begin
        if (ptr[g] >= exp_q.size()) begin
          chk("unexpected_resp_valid", g, 32'd1, 32'd0);
        end else begin
          e = exp_q[ptr[g]];
          chk("resp_rdata", g, resp_rdata[g], e.data);
          chk("resp_err", g, {31'd0, resp_err[g]}, {31'd0, e.err});
          chk("resp_latency", g, cyc - e.cyc, Lat);
          ptr[g]++;
        end
      end
    end
  end

  // Called at #1 after a rising edge; the request is accepted on the next edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_data,
                       input logic exp_err);
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    e.err  = exp_err;
    e.data = exp_data;
    e.cyc  = cyc;
    exp_q.push_back(e);
`ifdef MEM_STATS_EN
    if (exp_err) exp_err_cnt++;
    else if (we) exp_wr++;
    else exp_rd++;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Assert reset (dropping anything in flight), check quiet outputs, release,
  // then measure the init phase with req_valid held high.
  task automatic reset_phase();
    int cnt [NDut];
    int n;
    reset     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'd5;
    for (int g = 0; g < NDut; g++) ptr[g] = exp_q.size();
`ifdef MEM_STATS_EN
    exp_rd = 0;
    exp_wr = 0;
    exp_err_cnt = 0;
`endif
    repeat (3) begin
      @(negedge clk);
      for (int g = 0; g < NDut; g++) begin
        chk("rst_resp_valid", g, {31'd0, resp_valid[g]}, 32'd0);
        chk("rst_req_ready", g, {31'd0, req_ready[g]}, 32'd0);
        chk("rst_resp_rdata", g, resp_rdata[g], 32'd0);
        chk("rst_resp_err", g, {31'd0, resp_err[g]}, 32'd0);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int g = 0; g < NDut; g++) cnt[g] = 0;
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      if (req_ready[0] && req_ready[1] && req_ready[2]) break;
      for (int g = 0; g < NDut; g++) if (!req_ready[g]) cnt[g]++;
      n++;
    end
    req_valid = 1'b0;
    for (int g = 0; g < NDut; g++) chk("init_cycles", g, cnt[g], 32'd256);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    n_pass    = 0;
    n_total   = 0;
    for (int g = 0; g < NDut; g++) ptr[g] = 0;
`ifdef MEM_STATS_EN
    exp_rd = 0;
    exp_wr = 0;
    exp_err_cnt = 0;
`endif
    @(posedge clk);
    #1;
    reset_phase();

    // Freshly zeroed array.
    issue(1'b0, 32'd5, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    idle(1);

    // Full write then read of the same word on the next cycle.
    issue(1'b1, 32'd1, 32'h0000_0002, 4'hF, 32'h0, 1'b0);
    issue(1'b0, 32'd1, 32'h0, 4'h0, 32'h0000_0002, 1'b0);
    idle(1);

    // Partial write: lanes 0 and 2 take the new bytes.
    issue(1'b1, 32'd1, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    issue(1'b1, 32'd1, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
    issue(1'b0, 32'd1, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
    idle(2);

    // Back-to-back reads.
    issue(1'b0, 32'd0, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    issue(1'b0, 32'd1, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
    issue(1'b0, 32'd2, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    issue(1'b0, 32'd3, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    idle(2);

    // Out-of-range accesses and aliasing candidates.
    issue(1'b1, 32'd256, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    issue(1'b0, 32'd256, 32'h0, 4'h0, 32'h0, 1'b1);
    issue(1'b0, 32'd0, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    issue(1'b1, 32'h0000_0101, 32'h0, 4'hF, 32'h0, 1'b1);
    issue(1'b1, 32'h8000_0003, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1);
    issue(1'b0, 32'd1, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
    issue(1'b0, 32'd3, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    issue(1'b0, 32'd255, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    idle(1);

    // Byte-enable-free write is a no-op but still answers.
    issue(1'b1, 32'd2, 32'h5555_5555, 4'h0, 32'h0, 1'b0);
    issue(1'b0, 32'd2, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    issue(1'b1, 32'd255, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    issue(1'b0, 32'd255, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    idle(6);

    // Reset with two reads in flight; the array must be re-zeroed afterwards.
    issue(1'b0, 32'd255, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    issue(1'b0, 32'd1, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
    reset_phase();

    issue(1'b0, 32'd1, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    issue(1'b0, 32'd255, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    issue(1'b1, 32'd4, 32'h0000_0007, 4'hF, 32'h0, 1'b0);
    issue(1'b0, 32'd4, 32'h0, 4'h0, 32'h0000_0007, 1'b0);
    issue(1'b0, 32'd300, 32'h0, 4'h0, 32'h0, 1'b1);
    idle(8);

    for (int g = 0; g < NDut; g++) chk("all_responses_seen", g, ptr[g], exp_q.size());
`ifdef MEM_STATS_EN
    for (int g = 0; g < NDut; g++) begin
      chk("rd_count", g, rd_cnt[g], exp_rd);
      chk("wr_count", g, wr_cnt[g], exp_wr);
      chk("err_count", g, {16'd0, err_cnt[g]}, exp_err_cnt);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
